commit_trace_fifo: RTL and testbench

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/riscv_pkg.sv | 12 +
 rtl/trace_fifo_ram.sv | 28 ++
 rtl/commit_trace_fifo.sv | 118 +++++++++++
 tb/tb_commit_trace_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V types: XLEN and the commit-trace entry layout used by the
// core, the commit trace FIFO and the host-side trace consumer.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_ram.sv
// Entry storage for the commit trace FIFO: DEPTH words, one synchronous
// write port and one asynchronous read port so the head entry falls through.
// Contents are deliberately left unreset; occupancy is tracked elsewhere.
module trace_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the incoming entry at the tail slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: buffers {pc, data} of retired instructions for a host.
// Full FIFO drops new entries and raises a sticky overflow flag.
// Optional drop counter compiled in with macro COMMIT_TRACE_DROP_CNT_EN;
// without it drop_cnt_o is tied to zero.
module commit_trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            data_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_ramWe;
  trace_entry_t  w_wrEntry;
  trace_entry_t  w_rdEntry;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when the host is draining it.
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_count != '0) && ready_i;
  assign w_push    = update_i && (!w_full || w_pop);
  assign w_drop    = update_i && w_full && !w_pop;
  assign w_ramWe   = w_push && !flush_i && rstn_i;
  assign w_wrEntry = '{pc: pc_i, data: data_i};

  trace_fifo_ram #(
    .DEPTH (DEPTH),
    .W     ($bits(trace_entry_t)),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ramWe),
    .waddr_i (r_wrPtr),
    .wdata_i (w_wrEntry),
    .raddr_i (r_rdPtr),
    .rdata_o (w_rdEntry)
  );

  // Advance pointers and occupancy; flush and reset discard everything.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky overflow flag, set by any dropped entry until reset or flush.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef COMMIT_TRACE_DROP_CNT_EN
  logic [CNT_W-1:0] r_dropCnt;

  // Count dropped entries, saturating at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + CNT_W'(1);
    end
  end

  assign drop_cnt_o = r_dropCnt;
`else
  assign drop_cnt_o = '0;
`endif

  assign valid_o    = (r_count != '0);
  assign pc_o       = w_rdEntry.pc;
  assign data_o     = w_rdEntry.data;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed self-checking bench for commit_trace_fifo at DEPTH=4, XLEN=32.
// Drop-count expectations follow COMMIT_TRACE_DROP_CNT_EN (zero when absent).
module tb_commit_trace_fifo;

`ifdef COMMIT_TRACE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        update;
  logic [31:0] pcIn;
  logic [31:0] dataIn;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] pcOut;
  logic [31:0] dataOut;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] dropCnt;

  int checks   = 0;
  int failures = 0;

  commit_trace_fifo #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .update_i   (update),
    .pc_i       (pcIn),
    .data_i     (dataIn),
    .flush_i    (flush),
    .valid_o    (valid),
    .ready_i    (ready),
    .pc_o       (pcOut),
    .data_o     (dataOut),
    .count_o    (count),
    .overflow_o (overflow),
    .drop_cnt_o (dropCnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs without advancing time.
  task automatic driveInputs(input logic upd, input logic [31:0] pc, input logic [31:0] data,
                             input logic rdy, input logic fl, input logic rst);
    update = upd;
    pcIn   = pc;
    dataIn = data;
    ready  = rdy;
    flush  = fl;
    rstn   = rst;
  endtask

  // Advance one clock edge, then settle 1 ns past it.
  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus and return to idle inputs afterwards.
  task automatic applyStimulus(input logic upd, input logic [31:0] pc, input logic [31:0] data,
                               input logic rdy, input logic fl, input logic rst);
    driveInputs(upd, pc, data, rdy, fl, rst);
    tickClock();
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Status check of occupancy and flags in one call.
  task automatic checkStatus(input string tag, input int expCount, input logic expOvf, input int expDrop);
    checkOutput({tag, ".count"},    32'(count),    32'(expCount));
    checkOutput({tag, ".valid"},    32'(valid),    32'(expCount != 0));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, ".dropCnt"},  32'(dropCnt),  DROP_EN ? 32'(expDrop) : 32'h0);
  endtask

  // Stimulus sequence: each block sets up a scenario then checks results.
  initial begin
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tickClock();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkStatus("reset", 0, 1'b0, 0);

    // Single push becomes visible the cycle after.
    driveInputs(1'b1, 32'h0, 32'h11, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("push1.noBypass", 32'(valid), 32'h0);
    tickClock();
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("push1.pc",   pcOut,   32'h0);
    checkOutput("push1.data", dataOut, 32'h11);
    checkStatus("push1", 1, 1'b0, 0);

    // Six pushes into a depth-4 FIFO: last two dropped, order kept.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1);
    end
    checkStatus("overflow", 4, 1'b1, 2);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("overflow.holdPc", pcOut, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d.pc", i),   pcOut,   32'(4 * i));
      checkOutput($sformatf("drain%0d.data", i), dataOut, 32'hA0 + 32'(i));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    end
    checkStatus("drained", 0, 1'b1, 2);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkStatus("popEmpty", 0, 1'b1, 2);

    // Push and pop together while full: no drop, head advances.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b1);
    end
    checkStatus("full", 4, 1'b0, 0);
    applyStimulus(1'b1, 32'h200, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    checkStatus("fullPushPop", 4, 1'b0, 0);
    checkOutput("fullPushPop.pc", pcOut, 32'h104);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fullDrain%0d.pc", i), pcOut,
                  (i == 3) ? 32'h200 : 32'h104 + 32'(4 * i));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    end
    checkStatus("fullDrained", 0, 1'b0, 0);

    // Flush with a same-cycle push after an overflow clears everything.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkStatus("preFlush", 3, 1'b1, 1);
    checkOutput("preFlush.pc", pcOut, 32'h304);
    applyStimulus(1'b1, 32'h3F0, 32'hDEAD, 1'b1, 1'b1, 1'b1);
    checkStatus("flush", 0, 1'b0, 0);
    applyStimulus(1'b1, 32'h3F4, 32'hCAFE, 1'b0, 1'b0, 1'b1);
    checkOutput("postFlush.pc",   pcOut,   32'h3F4);
    checkOutput("postFlush.data", dataOut, 32'hCAFE);
    checkStatus("postFlush", 1, 1'b0, 0);

    // Ten back-to-back push/pop pairs wrap the pointers.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      driveInputs(1'b1, 32'h400 + 32'(4 * k), 32'hE0 + 32'(k), 1'b1, 1'b0, 1'b1);
      #1;
      if (k > 0) begin
        checkOutput($sformatf("stream%0d.pc", k - 1),   pcOut,   32'h400 + 32'(4 * (k - 1)));
        checkOutput($sformatf("stream%0d.data", k - 1), dataOut, 32'hE0 + 32'(k - 1));
      end
      tickClock();
      checkOutput($sformatf("stream%0d.count", k), 32'(count), 32'h1);
    end
    driveInputs(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("stream9.pc",   pcOut,   32'h424);
    checkOutput("stream9.data", dataOut, 32'hE9);
    tickClock();
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkStatus("streamEnd", 0, 1'b0, 0);

    // Reset mid-operation with three entries and a pending push/pop.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkStatus("preReset", 3, 1'b1, 1);
    applyStimulus(1'b1, 32'h5F0, 32'h5F, 1'b1, 1'b0, 1'b0);
    checkStatus("midReset", 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
